// File: rtl/tilelink_rr_arbiter_if.sv
// TileLink-UL A/D link bundle with N lanes, lane i at slice i.
// master: drives A payload/valid and d_ready. slave: drives a_ready and D.
interface tilelink_rr_arbiter_if #(
  parameter int N      = 1,
  parameter int SRC_W  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 4
);
  localparam int B = DATA_W / 8;

  logic [3*N-1:0]      a_opcode;
  logic [3*N-1:0]      a_param;
  logic [SIZE_W*N-1:0] a_size;
  logic [SRC_W*N-1:0]  a_source;
  logic [ADDR_W*N-1:0] a_address;
  logic [B*N-1:0]      a_mask;
  logic [DATA_W*N-1:0] a_data;
  logic [N-1:0]        a_corrupt;
  logic [N-1:0]        a_valid;
  logic [N-1:0]        a_ready;

  logic [3*N-1:0]      d_opcode;
  logic [2*N-1:0]      d_param;
  logic [SIZE_W*N-1:0] d_size;
  logic [SRC_W*N-1:0]  d_source;
  logic [N-1:0]        d_denied;
  logic [DATA_W*N-1:0] d_data;
  logic [N-1:0]        d_corrupt;
  logic [N-1:0]        d_valid;
  logic [N-1:0]        d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source,
    output a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source,
    input  d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_source,
    input  a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source,
    output d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tilelink_rr_arbiter.sv
// Round-robin NUM_M:1 TileLink-UL arbiter, bursts hold the grant.
// clk/rst (sync, active-high); m_if: NUM_M master lanes; s_if: one slave lane.
module tilelink_rr_arbiter #(
  parameter int NUM_M  = 3,
  parameter int SRC_W  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 4
) (
  input  logic clk,
  input  logic rst,
  tilelink_rr_arbiter_if.slave  m_if,
  tilelink_rr_arbiter_if.master s_if
);
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW    = SRC_W + IDX_W;
  localparam int B     = DATA_W / 8;
  localparam int LGB   = $clog2(B);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_q;
  logic [7:0]       beats_q;
  logic             first_q;

  logic [IDX_W-1:0] grant_d;
  logic             req_any;
  logic             busy;
  logic             hs;
  logic [7:0]       beats_m1;
  logic [IDX_W-1:0] d_idx;

  assign busy = (state_q == BUSY) && !rst;
  assign hs   = s_if.a_valid[0] & s_if.a_ready[0];

  // Indices above last win first, then wrap to the low ones.
  always_comb begin
    grant_d = last_q;
    req_any = 1'b0;
    for (int i = 0; i < NUM_M; i++)
      if (!req_any && m_if.a_valid[i] && IDX_W'(i) > last_q) begin
        req_any = 1'b1;
        grant_d = IDX_W'(i);
      end
    for (int i = 0; i < NUM_M; i++)
      if (!req_any && m_if.a_valid[i] && IDX_W'(i) <= last_q) begin
        req_any = 1'b1;
        grant_d = IDX_W'(i);
      end
  end

  always_comb begin
    s_if.a_opcode  = '0;
    s_if.a_param   = '0;
    s_if.a_size    = '0;
    s_if.a_source  = '0;
    s_if.a_address = '0;
    s_if.a_mask    = '0;
    s_if.a_data    = '0;
    s_if.a_corrupt = '0;
    s_if.a_valid   = '0;
    m_if.a_ready   = '0;
    for (int i = 0; i < NUM_M; i++)
      if (grant_q == IDX_W'(i)) begin
        s_if.a_opcode  = m_if.a_opcode[3*i +: 3];
        s_if.a_param   = m_if.a_param[3*i +: 3];
        s_if.a_size    = m_if.a_size[SIZE_W*i +: SIZE_W];
        s_if.a_source  = {grant_q, m_if.a_source[SRC_W*i +: SRC_W]};
        s_if.a_address = m_if.a_address[ADDR_W*i +: ADDR_W];
        s_if.a_mask    = m_if.a_mask[B*i +: B];
        s_if.a_data    = m_if.a_data[DATA_W*i +: DATA_W];
        s_if.a_corrupt = m_if.a_corrupt[i];
        s_if.a_valid   = busy & m_if.a_valid[i];
        m_if.a_ready[i] = busy & s_if.a_ready[0];
      end
  end

  // Beats after the first one; only Put opcodes carry multi-beat data.
  always_comb begin
    beats_m1 = '0;
    if (s_if.a_opcode inside {3'd0, 3'd1} &&
        s_if.a_size > SIZE_W'(LGB))
      beats_m1 = 8'(9'd1 << (s_if.a_size - SIZE_W'(LGB))) - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_M - 1);
      beats_q <= '0;
      first_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_any) begin
          grant_q <= grant_d;
          first_q <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: if (hs) begin
          if (first_q) begin
            last_q  <= grant_q;
            first_q <= 1'b0;
            beats_q <= beats_m1;
            if (beats_m1 == 8'd0) state_q <= IDLE;
          end else begin
            beats_q <= beats_q - 8'd1;
            if (beats_q == 8'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_idx = s_if.d_source[SW-1:SRC_W];

  // Unmapped tags match no lane: ready stays 1 and the beat is dropped.
  always_comb begin
    m_if.d_valid = '0;
    s_if.d_ready = 1'b1;
    for (int i = 0; i < NUM_M; i++)
      if (d_idx == IDX_W'(i)) begin
        m_if.d_valid[i] = s_if.d_valid[0];
        s_if.d_ready    = m_if.d_ready[i];
      end
  end

  assign m_if.d_opcode  = {NUM_M{s_if.d_opcode}};
  assign m_if.d_param   = {NUM_M{s_if.d_param}};
  assign m_if.d_size    = {NUM_M{s_if.d_size}};
  assign m_if.d_source  = {NUM_M{s_if.d_source[SRC_W-1:0]}};
  assign m_if.d_denied  = {NUM_M{s_if.d_denied}};
  assign m_if.d_data    = {NUM_M{s_if.d_data}};
  assign m_if.d_corrupt = {NUM_M{s_if.d_corrupt}};
endmodule

// File: tb/tb_tilelink_rr_arbiter.sv
// Bench for tilelink_rr_arbiter: directed scenarios plus random traffic
// checked against a transaction-level round-robin model.
module tb_tilelink_rr_arbiter;
  localparam int NUM_M  = 3;
  localparam int SRC_W  = 1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 4;
  localparam int SW     = SRC_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tilelink_rr_arbiter_if #(
    .N(NUM_M), .SRC_W(SRC_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .SIZE_W(SIZE_W)
  ) m_if ();
  tilelink_rr_arbiter_if #(
    .N(1), .SRC_W(SW), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .SIZE_W(SIZE_W)
  ) s_if ();

  tilelink_rr_arbiter #(
    .NUM_M(NUM_M), .SRC_W(SRC_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .SIZE_W(SIZE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_if(m_if),
    .s_if(s_if)
  );

  bit              rv[NUM_M];
  int              rop[NUM_M];
  int              rsz[NUM_M];
  bit [SRC_W-1:0]  rsrc[NUM_M];
  bit [31:0]       raddr[NUM_M];
  bit [31:0]       rdata[NUM_M];
  int              rleft[NUM_M];
  bit              rearm = 1'b0;

  bit              sa_rdy = 1'b0;
  bit              sd_valid = 1'b0;
  bit [SW-1:0]     sd_src = '0;
  bit [31:0]       sd_data = '0;
  bit [NUM_M-1:0]  md_rdy = '1;

  bit mb = 1'b0;
  int mg = 0;
  int ml = NUM_M - 1;
  int mrem = 0;

  int       glog[$];
  bit [2:0] hs_src[NUM_M];
  int       n_chk = 0;
  int       n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int nbeats(input int op, input int sz);
    if ((op == 0 || op == 1) && sz > 2) return 1 << (sz - 2);
    return 1;
  endfunction

  task automatic start(input int i, input int op, input int sz,
                       input bit [SRC_W-1:0] src);
    rv[i]    = 1'b1;
    rop[i]   = op;
    rsz[i]   = sz;
    rsrc[i]  = src;
    raddr[i] = $urandom;
    rdata[i] = $urandom;
    rleft[i] = nbeats(op, sz);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_M; i++) begin
      m_if.a_valid[i]            = rv[i];
      m_if.a_opcode[3*i +: 3]    = 3'(rop[i]);
      m_if.a_param[3*i +: 3]     = 3'd0;
      m_if.a_size[4*i +: 4]      = 4'(rsz[i]);
      m_if.a_source[i]           = rsrc[i];
      m_if.a_address[32*i +: 32] = raddr[i];
      m_if.a_mask[4*i +: 4]      = 4'hf;
      m_if.a_data[32*i +: 32]    = rdata[i];
      m_if.a_corrupt[i]          = 1'b0;
    end
    m_if.d_ready   = md_rdy;
    s_if.a_ready   = sa_rdy;
    s_if.d_valid   = sd_valid;
    s_if.d_source  = sd_src;
    s_if.d_data    = sd_data;
    s_if.d_opcode  = 3'd1;
    s_if.d_param   = 2'd0;
    s_if.d_size    = 4'd2;
    s_if.d_denied  = 1'b0;
    s_if.d_corrupt = 1'b0;
  endtask

  task automatic cycle();
    bit sav;
    bit hs;
    bit [NUM_M-1:0] mrdy;
    bit [NUM_M-1:0] mdv;
    bit sdr;
    int di;
    drive();
    @(negedge clk);
    sav  = !rst && mb && rv[mg];
    hs   = sav && sa_rdy;
    mrdy = '0;
    if (hs) mrdy[mg] = 1'b1;
    chk("s_a_valid", s_if.a_valid, sav);
    chk("m_a_ready", m_if.a_ready, mrdy);
    if (sav) begin
      chk("s_a_source", s_if.a_source, {mg[1:0], rsrc[mg]});
      chk("s_a_opcode", s_if.a_opcode, rop[mg]);
      chk("s_a_size", s_if.a_size, rsz[mg]);
      chk("s_a_address", s_if.a_address, raddr[mg]);
      chk("s_a_data", s_if.a_data, rdata[mg]);
    end
    di  = int'(sd_src) >> SRC_W;
    mdv = '0;
    sdr = 1'b1;
    if (di < NUM_M) begin
      mdv[di] = sd_valid;
      sdr     = md_rdy[di];
    end
    chk("m_d_valid", m_if.d_valid, mdv);
    chk("s_d_ready", s_if.d_ready, sdr);
    chk("m_d_source", m_if.d_source, {NUM_M{sd_src[SRC_W-1:0]}});
    chk("m_d_data", m_if.d_data, {NUM_M{sd_data}});
    for (int i = 0; i < NUM_M; i++)
      if (m_if.a_valid[i] && m_if.a_ready[i]) begin
        glog.push_back(i);
        hs_src[i] = s_if.a_source;
      end
    if (rst) begin
      mb = 1'b0;
      ml = NUM_M - 1;
    end else if (!mb) begin
      for (int k = 1; k <= NUM_M; k++) begin
        int c;
        c = (ml + k) % NUM_M;
        if (rv[c]) begin
          mb   = 1'b1;
          mg   = c;
          mrem = nbeats(rop[c], rsz[c]);
          break;
        end
      end
    end else if (hs) begin
      ml = mg;
      mrem--;
      if (mrem == 0) mb = 1'b0;
    end
    if (hs) begin
      rleft[mg]--;
      rdata[mg] = $urandom;
      if (rleft[mg] == 0) begin
        rv[mg] = 1'b0;
        if (rearm) start(mg, 4, 2, rsrc[mg]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_M; i++) rv[i] = 1'b0;
  endtask

  initial begin
    int e2[4];
    int e3[5];
    e2 = '{0, 1, 2, 0};
    e3 = '{1, 1, 1, 1, 0};
    clear_reqs();
    repeat (2) cycle();
    rst = 1'b0;

    rearm  = 1'b1;
    sa_rdy = 1'b1;
    start(0, 4, 2, 1'b1);
    start(1, 4, 2, 1'b0);
    start(2, 4, 2, 1'b1);
    glog.delete();
    repeat (8) cycle();
    rearm = 1'b0;
    clear_reqs();
    chk("rr_count", glog.size(), 4);
    for (int k = 0; k < 4; k++)
      if (glog.size() > k) chk("rr_order", glog[k], e2[k]);
    chk("src_m2", hs_src[2], 3'b101);

    glog.delete();
    start(1, 0, 4, 1'b0);
    start(0, 4, 2, 1'b0);
    repeat (3) cycle();
    sa_rdy = 1'b0;
    repeat (5) cycle();
    sa_rdy = 1'b1;
    repeat (4) cycle();
    chk("burst_count", glog.size(), 5);
    for (int k = 0; k < 5; k++)
      if (glog.size() > k) chk("burst_order", glog[k], e3[k]);

    sd_valid = 1'b1;
    sd_src   = 3'b011;
    sd_data  = 32'hcafe_f00d;
    md_rdy   = 3'b111;
    cycle();
    chk("d_valid_m1", m_if.d_valid, 3'b010);
    chk("d_source_m1", m_if.d_source, 3'b111);
    chk("d_ready_m1", s_if.d_ready, 1'b1);
    md_rdy = 3'b101;
    cycle();
    chk("d_ready_bp", s_if.d_ready, 1'b0);
    sd_src = 3'b110;
    cycle();
    chk("d_valid_idx3", m_if.d_valid, 3'b000);
    chk("d_ready_idx3", s_if.d_ready, 1'b1);
    sd_valid = 1'b0;
    md_rdy   = 3'b111;

    start(2, 0, 4, 1'b1);
    repeat (3) cycle();
    rst = 1'b1;
    clear_reqs();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_sav", s_if.a_valid, 1'b0);
    start(1, 4, 2, 1'b0);
    start(2, 4, 2, 1'b0);
    glog.delete();
    repeat (2) cycle();
    chk("rst_first", glog.size() > 0 ? glog[0] : -1, 1);
    repeat (2) cycle();
    clear_reqs();
    repeat (2) cycle();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_M; i++)
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          int ops[3];
          ops = '{0, 1, 4};
          start(i, ops[$urandom_range(0, 2)],
                $urandom_range(0, 4), SRC_W'($urandom));
        end
      sa_rdy   = ($urandom_range(0, 3) != 0);
      sd_valid = $urandom_range(0, 1) == 1;
      sd_src   = SW'($urandom);
      sd_data  = $urandom;
      md_rdy   = NUM_M'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
